// File: rtl/axi_slave_responder.sv
// AXI4 slave over a word array with independent write and read engines, each holding one burst at a time.
// The first read beat appears one cycle after the ar handshake; every channel stalls cleanly on valid/ready.
module axi_slave_responder #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] aw_addr,
    input  logic [7:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_burst,
    input  logic [3:0]  aw_id,
    input  logic        aw_valid,
    output logic        aw_ready,

    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    input  logic        w_valid,
    output logic        w_ready,

    output logic [3:0]  b_id,
    output logic [1:0]  b_resp,
    output logic        b_valid,
    input  logic        b_ready,

    input  logic [31:0] ar_addr,
    input  logic [7:0]  ar_len,
    input  logic [2:0]  ar_size,
    input  logic [1:0]  ar_burst,
    input  logic [3:0]  ar_id,
    input  logic        ar_valid,
    output logic        ar_ready,

    output logic [31:0] r_data,
    output logic [1:0]  r_resp,
    output logic        r_last,
    output logic [3:0]  r_id,
    output logic        r_valid,
    input  logic        r_ready
);

    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [MEM_WORDS];

    // 33-bit difference so an address below the base shows up as a borrow.
    function automatic logic in_range(input logic [31:0] addr);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[32] && ((diff[31:0] >> 2) < MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

    function automatic logic bad_attr(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || burst[1];
    endfunction

    w_state_t    w_state;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len;
    logic [7:0]  wr_cnt;
    logic [1:0]  wr_burst;
    logic        wr_bad;
    logic        wr_err;
    logic        w_beat;
    logic        wr_hit;
    logic        wr_en;
    logic        beat_err;

    assign aw_ready = !rst && (w_state == W_IDLE);
    assign w_ready  = !rst && (w_state == W_DATA);
    assign b_valid  = !rst && (w_state == W_RESP);

    assign w_beat = w_valid && w_ready;
    assign wr_hit = in_range(wr_addr);
    assign wr_en  = w_beat && wr_hit && !wr_bad;
    // A beat is in error if out of range, or if w_last disagrees with the beat count in either direction.
    assign beat_err = !wr_hit || (w_last ? (wr_cnt != wr_len) : (wr_cnt == wr_len));

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            wr_addr  <= 32'h0;
            wr_len   <= 8'h0;
            wr_cnt   <= 8'h0;
            wr_burst <= 2'b00;
            wr_bad   <= 1'b0;
            wr_err   <= 1'b0;
            b_id     <= 4'h0;
            b_resp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_valid) begin
                        wr_addr  <= aw_addr;
                        wr_len   <= aw_len;
                        wr_cnt   <= 8'h0;
                        wr_burst <= aw_burst;
                        wr_bad   <= bad_attr(aw_size, aw_burst);
                        wr_err   <= bad_attr(aw_size, aw_burst);
                        b_id     <= aw_id;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        wr_addr <= next_addr(wr_addr, wr_burst);
                        wr_cnt  <= wr_cnt + 8'd1;
                        wr_err  <= wr_err | beat_err;
                        if (w_last) begin
                            b_resp  <= (wr_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    mem[word_idx(wr_addr)][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    r_state_t    r_state;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [7:0]  rd_cnt;
    logic [1:0]  rd_burst;
    logic        rd_bad;
    logic [31:0] look_addr;
    logic        look_ok;

    assign ar_ready = !rst && (r_state == R_IDLE);
    assign r_valid  = !rst && (r_state == R_DATA);

    // In idle the lookup serves beat 0 straight off the ar channel; afterwards it serves the next beat.
    assign look_addr = (r_state == R_IDLE) ? ar_addr : rd_addr;
    assign look_ok   = in_range(look_addr) &&
                       !((r_state == R_IDLE) ? bad_attr(ar_size, ar_burst) : rd_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            rd_addr  <= 32'h0;
            rd_len   <= 8'h0;
            rd_cnt   <= 8'h0;
            rd_burst <= 2'b00;
            rd_bad   <= 1'b0;
            r_data   <= 32'h0;
            r_resp   <= RESP_OKAY;
            r_last   <= 1'b0;
            r_id     <= 4'h0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_valid) begin
                        rd_addr  <= next_addr(ar_addr, ar_burst);
                        rd_len   <= ar_len;
                        rd_cnt   <= 8'h0;
                        rd_burst <= ar_burst;
                        rd_bad   <= bad_attr(ar_size, ar_burst);
                        r_id     <= ar_id;
                        r_last   <= (ar_len == 8'h0);
                        r_data   <= look_ok ? mem[word_idx(look_addr)] : 32'h0;
                        r_resp   <= look_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready) begin
                        if (r_last) begin
                            r_state <= R_IDLE;
                        end else begin
                            rd_addr <= next_addr(rd_addr, rd_burst);
                            rd_cnt  <= rd_cnt + 8'd1;
                            r_last  <= ((rd_cnt + 8'd1) == rd_len);
                            r_data  <= look_ok ? mem[word_idx(look_addr)] : 32'h0;
                            r_resp  <= look_ok ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
            endcase
        end
    end

endmodule
